// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction fetch stage for simple_cpu. Holds a writable program memory
// and walks a program counter through it, presenting each word for a fixed
// number of rising edges. Fetch stops on an all-zero HALT word or after the
// last address. The CPU sees zeros (NOP) whenever nothing is being issued.
//
// Ports:
//   clk          in   single clock, rising-edge active
//   rst          in   asynchronous, active-low reset
//   prog_we      in   program write enable (honoured in IDLE/HALT only)
//   prog_addr    in   [PC_BITS-1:0]     program write address
//   prog_data    in   [INSTR_WIDTH-1:0] program write data
//   start        in   begin a run from address 0 (level sampled)
//   stall        in   freeze the hold counter while issuing
//   abort        in   end the run, return to IDLE
//   instruction  out  [INSTR_WIDTH-1:0] word presented to the CPU
//   instr_valid  out  high while instruction carries an issued word
//   pc           out  [PC_BITS-1:0] address of the current word
//   halted       out  high in HALT
module instr_fetch_unit #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted
);

  localparam int          DEPTH       = 2 ** PC_BITS;
  localparam logic [3:0]  HOLD_RELOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [PC_BITS-1:0] PC_LAST = PC_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t                 state_q;
  logic [PC_BITS-1:0]     pc_q;
  logic [3:0]             cnt_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   halted_q;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic [PC_BITS-1:0]     pc_inc;
  logic [INSTR_WIDTH-1:0] word_cur;
  logic [INSTR_WIDTH-1:0] word_nxt;
  logic                   mem_we;
  logic                   go;

  always_comb begin
    pc_inc   = pc_q + PC_BITS'(1);
    word_cur = mem_q[pc_q];
    word_nxt = mem_q[pc_inc];
    mem_we   = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));
    // A simultaneous program write takes precedence over start.
    go       = start && !prog_we;
  end

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // instr_q drives the output directly, so it is zeroed whenever nothing is
  // issued; this keeps every output a plain register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (abort) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
          end
        end

        S_FETCH: begin
          if (word_cur == '0) begin
            state_q  <= S_HALT;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
            instr_q <= word_cur;
            valid_q <= 1'b1;
            cnt_q   <= HOLD_RELOAD;
          end
        end

        S_ISSUE: begin
          if (!stall) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 4'd1;
            end else if (pc_q == PC_LAST) begin
              state_q  <= S_HALT;
              instr_q  <= '0;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              // Prefetch the next word on the expiry edge so there is no bubble.
              pc_q <= pc_inc;
              if (word_nxt == '0) begin
                state_q  <= S_HALT;
                instr_q  <= '0;
                valid_q  <= 1'b0;
                halted_q <= 1'b1;
              end else begin
                instr_q <= word_nxt;
                cnt_q   <= HOLD_RELOAD;
              end
            end
          end
        end

        S_HALT: begin
          if (go) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            halted_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic        start;
  logic        stall;
  logic        abort;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        halted;

  int unsigned total;
  int unsigned bad;

  logic [19:0] prog [4];

  instr_fetch_unit #(
    .INSTR_WIDTH(20),
    .PC_BITS(5),
    .HOLD_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start(start),
    .stall(stall),
    .abort(abort),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc(pc),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    prog[0] = 20'h47000;
    prog[1] = 20'h53000;
    prog[2] = 20'h72001;
    prog[3] = 20'h00000;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; stall = 1'b0; abort = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic program
    for (int i = 0; i < 4; i++) write_word(5'(i), prog[i]);
    pulse_start();
    check("fetch_valid", 32'(instr_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      for (int h = 0; h < 3; h++) begin
        tick();
        check("basic_instr", 32'(instruction), 32'(prog[k]));
        check("basic_valid", 32'(instr_valid), 32'h1);
        check("basic_pc", 32'(pc), 32'(k));
      end
    end
    tick();
    check("basic_halt_instr", 32'(instruction), 32'h0);
    check("basic_halt_valid", 32'(instr_valid), 32'h0);
    check("basic_halted", 32'(halted), 32'h1);
    check("basic_halt_pc", 32'(pc), 32'h3);

    // Stall: word 1 held for 5 edges
    pulse_start();
    for (int h = 0; h < 3; h++) begin
      tick();
      check("stall_w0", 32'(instruction), 32'h47000);
    end
    for (int h = 0; h < 5; h++) begin
      if (h == 1) stall = 1'b1;
      if (h == 3) stall = 1'b0;
      tick();
      check("stall_w1", 32'(instruction), 32'h53000);
      check("stall_pc", 32'(pc), 32'h1);
    end
    tick();
    check("stall_w2", 32'(instruction), 32'h72001);
    tick(); tick(); tick();
    check("stall_halted", 32'(halted), 32'h1);
    check("stall_halt_pc", 32'(pc), 32'h3);

    // Asynchronous reset mid-ISSUE, memory retained
    pulse_start();
    tick(); tick();
    check("pre_rst_instr", 32'(instruction), 32'h47000);
    rst = 1'b0;
    #1;
    check("arst_instr", 32'(instruction), 32'h0);
    check("arst_valid", 32'(instr_valid), 32'h0);
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_halted", 32'(halted), 32'h0);
    rst = 1'b1;
    tick();
    pulse_start();
    tick();
    check("rerun_w0", 32'(instruction), 32'h47000);
    tick(); tick(); tick();
    check("rerun_w1", 32'(instruction), 32'h53000);

    // Abort during second word
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_instr", 32'(instruction), 32'h0);
    check("abort_valid", 32'(instr_valid), 32'h0);
    check("abort_pc", 32'(pc), 32'h0);
    check("abort_halted", 32'(halted), 32'h0);
    tick();
    check("abort_idle_valid", 32'(instr_valid), 32'h0);
    pulse_start();
    tick();
    check("abort_restart", 32'(instruction), 32'h47000);
    for (int i = 0; i < 9; i++) tick();
    check("abort_run_halted", 32'(halted), 32'h1);

    // Write gating: write during ISSUE ignored
    pulse_start();
    tick();
    write_word(5'd1, 20'h11111);
    for (int i = 0; i < 8; i++) tick();
    check("gate_halted", 32'(halted), 32'h1);
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    check("gate_w1_kept", 32'(instruction), 32'h53000);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // start + prog_we in IDLE: write lands, stays IDLE
    write_word(5'd4, 20'h00000);
    start = 1'b1; prog_we = 1'b1; prog_addr = 5'd3; prog_data = 20'h12345;
    tick();
    start = 1'b0; prog_we = 1'b0;
    check("sw_valid0", 32'(instr_valid), 32'h0);
    tick();
    check("sw_valid1", 32'(instr_valid), 32'h0);
    check("sw_instr", 32'(instruction), 32'h0);
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    check("sw_w3", 32'(instruction), 32'h12345);
    check("sw_pc3", 32'(pc), 32'h3);
    tick(); tick(); tick();
    check("sw_halted", 32'(halted), 32'h1);
    check("sw_halt_pc", 32'(pc), 32'h4);

    // End of memory: 32 words, no wrap
    for (int i = 0; i < 32; i++) write_word(5'(i), 20'hDB0F0);
    pulse_start();
    for (int k = 0; k < 32; k++) begin
      for (int h = 0; h < 3; h++) begin
        tick();
        check("eom_instr", 32'(instruction), 32'hDB0F0);
        check("eom_pc", 32'(pc), 32'(k));
      end
    end
    tick();
    check("eom_halted", 32'(halted), 32'h1);
    check("eom_instr_zero", 32'(instruction), 32'h0);
    check("eom_pc_last", 32'(pc), 32'd31);
    tick();
    check("eom_no_wrap", 32'(pc), 32'd31);
    check("eom_still_halted", 32'(halted), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
